if_id_frontend: RTL
===================

Name: if_id_frontend

Overview:
- Consumer end of the load-use hazard interface. Owns the PC register, the IF/ID pipeline register and the ID/EX control-field register.
- Applies the hazard unit's `pc_ifwrite` (hold) and `stall` (bubble) outputs, together with branch and jump redirects, so that the pipeline freezes, bubbles and flushes correctly.
- Sits between instruction memory and the decoder / ID/EX datapath register.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CTRL_W, 10, width of the decoded EX/MEM/WB control bundle.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_ifwrite  in  1  from hazard unit; 0 = hold PC and IF/ID
- stall  in  1  from hazard unit; 1 = insert bubble into ID/EX
- branch_taken_ex  in  1  taken branch resolved in EX
- branch_target_ex  in  32  branch target address
- jump_id  in  1  jump decoded in ID
- jump_target_id  in  32  jump target address
- imem_rdata  in  32  combinational instruction word at imem_addr
- ctrl_id  in  CTRL_W  decoder control bundle for the instruction in ID
- imem_addr  out  32  equals pc
- pc  out  32  current fetch PC
- ifid_instr  out  32  IF/ID instruction
- ifid_pc_plus4  out  32  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction
- idex_ctrl  out  CTRL_W  ID/EX control bundle
- idex_valid  out  1  ID/EX holds a real instruction
- stall_cnt  out  CNT_W  count of applied bubble cycles
- flush_cnt  out  CNT_W  count of redirects

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - pc=RESET_PC
  - ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0
  - idex_ctrl=0, idex_valid=0
  - both counters=0
  - rst has priority over all other inputs, including mid-stall and mid-flush.
- PC update priority per cycle (highest first):
  1. branch_taken_ex → pc=branch_target_ex
  2. pc_ifwrite=0 → pc holds
  3. jump_id → pc=jump_target_id
  4. otherwise → pc=pc+4 (32-bit, wraps at 2^32).
- IF/ID register:
  - branch_taken_ex: instr=0 (NOP), pc_plus4=0, valid=0. Flush overrides hold.
  - else pc_ifwrite=0: all fields hold.
  - else jump_id: instr=0, valid=0 (squash the delay-slot fetch).
  - else: instr=imem_rdata, pc_plus4=pc+4, valid=1.
- ID/EX control register:
  - branch_taken_ex or stall: idex_ctrl=0, idex_valid=0 (bubble).
  - else: idex_ctrl = ctrl_id if ifid_valid, else 0; idex_valid=ifid_valid.
  - A jump_id does not bubble ID/EX; the jump instruction itself advances.
- jump_id is ignored while pc_ifwrite=0. The jump is re-presented once the stall clears.
- Latency:
  - Fetched word appears on ifid_instr 1 cycle after its pc.
  - Redirect target appears on pc 1 cycle after branch_taken_ex or jump_id.
- Counters, saturating at all-ones:
  - stall_cnt increments when stall=1 and branch_taken_ex=0.
  - flush_cnt increments on branch_taken_ex, or on jump_id accepted (pc_ifwrite=1, branch_taken_ex=0).
- pc_ifwrite=0 with stall=0 is legal: hold without bubble; ID/EX still loads from IF/ID.
- Multi-cycle stalls are held indefinitely with no state drift.

Test Plan:
- Reset then 3 free-run cycles, imem_rdata=32'h1111_0000+pc → pc=3000,3004,3008,300C; ifid_instr follows one cycle behind; ifid_valid=1 from cycle 2.
- At pc=3008, assert pc_ifwrite=0 and stall=1 for 1 cycle → pc stays 3008 for one extra cycle; ifid_instr unchanged; idex_ctrl=0, idex_valid=0 that cycle; stall_cnt=1; next cycle resumes at 300C.
- Stall and branch_taken_ex same cycle, target 32'h0000_4000 → pc=4000, ifid_valid=0, idex_valid=0, stall_cnt unchanged, flush_cnt=1.
- jump_id=1, target 32'h0000_5000, pc_ifwrite=1 → pc=5000 next cycle; IF/ID squashed; idex_ctrl=ctrl_id; flush_cnt increments. Repeat with pc_ifwrite=0 → jump ignored, pc holds.
- pc=32'hFFFF_FFFC free-run → pc wraps to 0; ifid_pc_plus4=0.
- Force stall_cnt to 16'hFFFF via a long stall, then another stall cycle → stays FFFF. Assert rst mid-stall → all outputs at reset values next edge.

Source files
------------

// File: rtl/if_id_frontend.sv
// Fetch front end: PC register, IF/ID register and ID/EX control register.
// Applies hazard-unit hold/bubble and branch/jump redirects, with saturating debug counters.
module if_id_frontend #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CTRL_W   = 10,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_ifwrite,
    input  logic              stall,
    input  logic              branch_taken_ex,
    input  logic [31:0]       branch_target_ex,
    input  logic              jump_id,
    input  logic [31:0]       jump_target_id,
    input  logic [31:0]       imem_rdata,
    input  logic [CTRL_W-1:0] ctrl_id,
    output logic [31:0]       imem_addr,
    output logic [31:0]       pc,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc_plus4,
    output logic              ifid_valid,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              idex_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [31:0] pc_plus4;
    logic        jump_accepted;
    logic        bubble;

    assign pc_plus4      = pc + 32'd4;
    assign imem_addr     = pc;
    // A jump only counts while fetch is allowed to move; otherwise it is re-presented later.
    assign jump_accepted = jump_id && pc_ifwrite && !branch_taken_ex;
    assign bubble        = branch_taken_ex || stall;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            ifid_instr    <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
            idex_ctrl     <= '0;
            idex_valid    <= 1'b0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
        end else begin
            if (branch_taken_ex) begin
                pc            <= branch_target_ex;
                ifid_instr    <= '0;
                ifid_pc_plus4 <= '0;
                ifid_valid    <= 1'b0;
            end else if (pc_ifwrite) begin
                if (jump_id) begin
                    pc            <= jump_target_id;
                    ifid_instr    <= '0;
                    ifid_pc_plus4 <= '0;
                    ifid_valid    <= 1'b0;
                end else begin
                    pc            <= pc_plus4;
                    ifid_instr    <= imem_rdata;
                    ifid_pc_plus4 <= pc_plus4;
                    ifid_valid    <= 1'b1;
                end
            end

            if (bubble) begin
                idex_ctrl  <= '0;
                idex_valid <= 1'b0;
            end else begin
                idex_ctrl  <= ifid_valid ? ctrl_id : '0;
                idex_valid <= ifid_valid;
            end

            if (stall && !branch_taken_ex && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if ((branch_taken_ex || jump_accepted) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
